qea: RTL and testbench

//  Quantum-emulation accelerator: holds a 2^n-amplitude complex state vector across PE_NUM banks.
//  It runs a gate program from a context RAM, applying 1-qubit and controlled 1-qubit unitaries in fixed point.
//  The host loads the program and initial state, pulses i_start, waits for o_complete, then reads the state back.

---
 rtl/qea.sv | 209 ++++++++++++++++++++
 tb/tb_qea.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/qea.sv
// rtl/qea.sv - quantum-emulation accelerator: banked state vector, gate program engine
module qea #(
  parameter int PE_NUM_WIDTH            = 2,
  parameter int PE_NUM                  = 4,
  parameter int DATA_WIDTH              = 32,
  parameter int MAX_QBIT_WIDTH          = 6,
  parameter int ALU_DATA_WIDTH          = DATA_WIDTH,
  parameter int STATE_DATA_WIDTH        = 2*DATA_WIDTH,
  parameter int STATE_ADDR_WIDTH        = 16,
  parameter int GATE_DATA_WIDTH         = 2*DATA_WIDTH,
  parameter int GATE_ADDR_WIDTH         = 6,
  parameter int GATE_CONTEXT_DATA_WIDTH = 2*DATA_WIDTH,
  parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
  parameter int NUM_FRAC_BIT            = 30
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_start,
  input  logic [MAX_QBIT_WIDTH-1:0]          i_qbit_num,
  input  logic                               i_ctx_en,
  input  logic                               i_ctx_wea,
  input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0] i_ctx_addr,
  input  logic [GATE_CONTEXT_DATA_WIDTH-1:0] i_ctx_data,
  input  logic [PE_NUM-1:0]                  i_state_ena,
  input  logic [PE_NUM-1:0]                  i_state_wea,
  input  logic [STATE_ADDR_WIDTH-1:0]        i_state_addra,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0] i_state_dina,
  output logic                               o_complete,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0] o_state_dout
);
  localparam int IDX_W = STATE_ADDR_WIDTH + PE_NUM_WIDTH;
  localparam int PC_W  = GATE_CONTEXT_ADDR_WIDTH + 1;
  localparam int DW    = DATA_WIDTH;
  localparam int SDW   = STATE_DATA_WIDTH;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_LDU_WAIT, S_LDU,
    S_PR_K, S_PR_J, S_PCALC, S_PW_K, S_PW_J, S_DONE
  } state_t;
  state_t state, state_nx;

  logic [GATE_CONTEXT_DATA_WIDTH-1:0] ctx_mem [2**GATE_CONTEXT_ADDR_WIDTH];
  logic [GATE_CONTEXT_DATA_WIDTH-1:0] ctx_q;
  logic [GATE_DATA_WIDTH-1:0]         gate_buf [4];
  logic [PC_W-1:0]                    pc;
  logic [GATE_ADDR_WIDTH-1:0]         widx;
  logic [MAX_QBIT_WIDTH-1:0]          qn, tq, cq, hdr_t, hdr_c;
  logic [3:0]                         hdr_op;
  logic                               is_ctrl, gate_ok, hdr_ok, ctrl_ok, pair_last, busy;
  logic [IDX_W-1:0]                   m, low_mask, k_idx, j_idx, m_last, eng_idx;
  logic [SDW-1:0]                     ak_q, aj_q, new_k, new_j, eng_wdata;
  logic                               eng_we;
  logic [PE_NUM-1:0][SDW-1:0]         eng_q, dout_q;

  function automatic logic [DW-1:0] fx_mul(input logic [ALU_DATA_WIDTH-1:0] a, input logic [ALU_DATA_WIDTH-1:0] b);
    logic signed [2*ALU_DATA_WIDTH-1:0] p;
    logic        [2*ALU_DATA_WIDTH-1:0] s;
    p = $signed({{ALU_DATA_WIDTH{a[ALU_DATA_WIDTH-1]}}, a}) * $signed({{ALU_DATA_WIDTH{b[ALU_DATA_WIDTH-1]}}, b});
    s = p >>> NUM_FRAC_BIT;
    return s[DW-1:0];
  endfunction

  function automatic logic [SDW-1:0] cmul(input logic [SDW-1:0] a, input logic [SDW-1:0] b);
    logic [DW-1:0] re, im;
    re = fx_mul(a[SDW-1:DW], b[SDW-1:DW]) - fx_mul(a[DW-1:0], b[DW-1:0]);
    im = fx_mul(a[SDW-1:DW], b[DW-1:0]) + fx_mul(a[DW-1:0], b[SDW-1:DW]);
    return {re, im};
  endfunction

  function automatic logic [SDW-1:0] cadd(input logic [SDW-1:0] a, input logic [SDW-1:0] b);
    return {a[SDW-1:DW] + b[SDW-1:DW], a[DW-1:0] + b[DW-1:0]};
  endfunction

  assign busy       = !(state == S_IDLE || state == S_DONE);
  assign o_complete = (state == S_DONE);

  assign hdr_op = ctx_q[63:60];
  assign hdr_t  = ctx_q[57:52];
  assign hdr_c  = ctx_q[51:46];
  assign hdr_ok = (hdr_t < qn) && (hdr_op == 4'd1 || (hdr_c < qn && hdr_c != hdr_t));

  // Pair index: insert a zero at bit t of the pair counter to get k, set it to get j.
  assign low_mask  = (IDX_W'(1) << tq) - IDX_W'(1);
  assign k_idx     = ((m & ~low_mask) << 1) | (m & low_mask);
  assign j_idx     = k_idx | (IDX_W'(1) << tq);
  assign m_last    = (IDX_W'(1) << (qn - MAX_QBIT_WIDTH'(1))) - IDX_W'(1);
  assign pair_last = (m == m_last);
  assign ctrl_ok   = !is_ctrl || k_idx[cq];

  assign new_k = cadd(cmul(gate_buf[0], ak_q), cmul(gate_buf[1], aj_q));
  assign new_j = cadd(cmul(gate_buf[2], ak_q), cmul(gate_buf[3], aj_q));

  always_comb begin
    state_nx  = state;
    eng_idx   = k_idx;
    eng_we    = 1'b0;
    eng_wdata = new_k;
    case (state)
      S_IDLE, S_DONE: if (i_start) state_nx = S_FETCH;
      S_FETCH:        state_nx = pc[PC_W-1] ? S_DONE : S_DECODE;
      S_DECODE: begin
        if (hdr_op == 4'd0)                          state_nx = S_DONE;
        else if (hdr_op == 4'd1 || hdr_op == 4'd2)   state_nx = S_LDU_WAIT;
        else                                         state_nx = S_FETCH;
      end
      S_LDU_WAIT:     state_nx = S_LDU;
      S_LDU: begin
        if (widx == GATE_ADDR_WIDTH'(3)) state_nx = gate_ok ? S_PR_K : S_FETCH;
        else                             state_nx = S_LDU_WAIT;
      end
      S_PR_K: begin
        if (ctrl_ok)        state_nx = S_PR_J;
        else if (pair_last) state_nx = S_FETCH;
      end
      S_PR_J: begin
        eng_idx  = j_idx;
        state_nx = S_PCALC;
      end
      S_PCALC:        state_nx = S_PW_K;
      S_PW_K: begin
        eng_we   = 1'b1;
        state_nx = S_PW_J;
      end
      S_PW_J: begin
        eng_idx   = j_idx;
        eng_we    = 1'b1;
        eng_wdata = new_j;
        state_nx  = pair_last ? S_FETCH : S_PR_K;
      end
      default:        state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      pc      <= '0;
      qn      <= '0;
      tq      <= '0;
      cq      <= '0;
      is_ctrl <= 1'b0;
      gate_ok <= 1'b0;
      widx    <= '0;
      m       <= '0;
      ak_q    <= '0;
      aj_q    <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE, S_DONE: if (i_start) begin
          pc <= '0;
          qn <= i_qbit_num;
        end
        S_DECODE: begin
          pc      <= pc + PC_W'(1);
          tq      <= hdr_t;
          cq      <= hdr_c;
          is_ctrl <= (hdr_op == 4'd2);
          gate_ok <= hdr_ok;
          widx    <= '0;
          m       <= '0;
        end
        S_LDU: begin
          pc   <= pc + PC_W'(1);
          widx <= widx + GATE_ADDR_WIDTH'(1);
        end
        S_PR_K:  if (!ctrl_ok) m <= m + IDX_W'(1);
        S_PR_J:  ak_q <= eng_q[k_idx[PE_NUM_WIDTH-1:0]];
        S_PCALC: aj_q <= eng_q[j_idx[PE_NUM_WIDTH-1:0]];
        S_PW_J:  m <= m + IDX_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_LDU) gate_buf[widx[1:0]] <= ctx_q;
    if (i_ctx_en && i_ctx_wea && !busy) ctx_mem[i_ctx_addr] <= i_ctx_data;
    ctx_q <= ctx_mem[pc[GATE_CONTEXT_ADDR_WIDTH-1:0]];
  end

  // One port per bank, owned by the engine while busy and by the host otherwise.
  for (genvar p = 0; p < PE_NUM; p++) begin : g_bank
    logic [SDW-1:0]              mem [2**STATE_ADDR_WIDTH];
    logic [STATE_ADDR_WIDTH-1:0] addr;
    logic                        we;
    logic [SDW-1:0]              wdata, rd_eng, rd_host;

    assign addr  = busy ? eng_idx[IDX_W-1:PE_NUM_WIDTH] : i_state_addra;
    assign we    = busy ? (eng_we && eng_idx[PE_NUM_WIDTH-1:0] == PE_NUM_WIDTH'(p))
                        : (i_state_ena[p] && i_state_wea[p]);
    assign wdata = busy ? eng_wdata : i_state_dina[p*SDW +: SDW];

    always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      rd_eng <= mem[addr];
    end

    always_ff @(posedge clk) begin
      if (rst)                         rd_host <= '0;
      else if (!busy && i_state_ena[p]) rd_host <= mem[addr];
    end

    assign eng_q[p]  = rd_eng;
    assign dout_q[p] = rd_host;
  end

  assign o_state_dout = dout_q;
endmodule

// File: tb/tb_qea.sv
// tb/tb_qea.sv - self-checking bench for qea: gate-program cases against a reference model
module tb_qea;
  localparam logic [63:0] ONE = 64'h40000000_00000000;
  localparam logic [63:0] HV  = 64'h2D413CCD_00000000;
  localparam logic [63:0] HN  = 64'hD2BEC333_00000000;
  localparam int LIMIT = 20000;

  logic         clk = 1'b0;
  logic         rst, i_start, i_ctx_en, i_ctx_wea, o_complete;
  logic [5:0]   i_qbit_num;
  logic [15:0]  i_ctx_addr, i_state_addra;
  logic [63:0]  i_ctx_data;
  logic [3:0]   i_state_ena, i_state_wea;
  logic [255:0] i_state_dina, o_state_dout;

  always #5 clk = ~clk;

  qea dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_qbit_num(i_qbit_num),
    .i_ctx_en(i_ctx_en), .i_ctx_wea(i_ctx_wea), .i_ctx_addr(i_ctx_addr), .i_ctx_data(i_ctx_data),
    .i_state_ena(i_state_ena), .i_state_wea(i_state_wea), .i_state_addra(i_state_addra),
    .i_state_dina(i_state_dina), .o_complete(o_complete), .o_state_dout(o_state_dout)
  );

  typedef struct { logic [3:0] op; logic [5:0] t; logic [5:0] c; int mat; } gate_t;
  typedef struct {
    int n; bit rnd; int ng; gate_t g0; gate_t g1; gate_t g2;
    int spot; logic [255:0] spot_exp; bit poke; bit abort;
  } case_t;
  typedef struct { int addr; logic [255:0] exp; } rd_t;

  case_t       cases[7];
  rd_t         sb[$];
  logic [63:0] model[64];
  logic [63:0] init_m[64];
  int          checks = 0, errors = 0;

  function automatic logic [63:0] umat(int mat, int idx);
    logic [63:0] h[4], x[4], q[4];
    h = '{HV, HV, HV, HN};
    x = '{64'd0, ONE, ONE, 64'd0};
    q = '{64'h20000000_10000000, 64'hF0000000_30000000, 64'h12345678_EDCBA988, 64'h40000000_C0000000};
    case (mat)
      0:       return h[idx];
      1:       return x[idx];
      default: return q[idx];
    endcase
  endfunction

  function automatic logic [31:0] fxm(logic [31:0] a, logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    p = p >>> 30;
    return p[31:0];
  endfunction

  function automatic logic [63:0] cm(logic [63:0] u, logic [63:0] a);
    logic [31:0] re, im;
    re = fxm(u[63:32], a[63:32]) - fxm(u[31:0], a[31:0]);
    im = fxm(u[63:32], a[31:0]) + fxm(u[31:0], a[63:32]);
    return {re, im};
  endfunction

  function automatic logic [63:0] ca(logic [63:0] a, logic [63:0] b);
    logic [31:0] re, im;
    re = a[63:32] + b[63:32];
    im = a[31:0] + b[31:0];
    return {re, im};
  endfunction

  function automatic void model_gate(gate_t g, int n);
    logic [63:0] tmp[64];
    if (g.op != 4'd1 && g.op != 4'd2) return;
    if (int'(g.t) >= n) return;
    if (g.op == 4'd2 && (int'(g.c) >= n || g.c == g.t)) return;
    tmp = model;
    for (int k = 0; k < (1 << n); k++) begin
      if (((k >> g.t) & 1) == 0 && (g.op == 4'd1 || ((k >> g.c) & 1) == 1)) begin
        int j;
        j = k | (1 << g.t);
        model[k] = ca(cm(umat(g.mat, 0), tmp[k]), cm(umat(g.mat, 1), tmp[j]));
        model[j] = ca(cm(umat(g.mat, 2), tmp[k]), cm(umat(g.mat, 3), tmp[j]));
      end
    end
  endfunction

  function automatic logic [255:0] row(int a);
    return {model[4*a+3], model[4*a+2], model[4*a+1], model[4*a]};
  endfunction

  task automatic check(string name, logic [255:0] got, logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic ctx_wr(int a, logic [63:0] d);
    @(negedge clk);
    i_ctx_en = 1'b1; i_ctx_wea = 1'b1; i_ctx_addr = 16'(a); i_ctx_data = d;
    @(negedge clk);
    i_ctx_en = 1'b0; i_ctx_wea = 1'b0;
  endtask

  task automatic load_prog(case_t tc);
    gate_t gs[3];
    int a;
    gs = '{tc.g0, tc.g1, tc.g2};
    a = 0;
    for (int i = 0; i < tc.ng; i++) begin
      ctx_wr(a, {gs[i].op, 2'b00, gs[i].t, gs[i].c, 46'd0});
      a++;
      if (gs[i].op == 4'd1 || gs[i].op == 4'd2)
        for (int w = 0; w < 4; w++) begin
          ctx_wr(a, umat(gs[i].mat, w));
          a++;
        end
    end
    ctx_wr(a, 64'd0);
  endtask

  task automatic write_state(int n);
    model = init_m;
    for (int a = 0; a < (1 << n) / 4; a++) begin
      @(negedge clk);
      i_state_ena = 4'hf; i_state_wea = 4'hf; i_state_addra = 16'(a); i_state_dina = row(a);
    end
    @(negedge clk);
    i_state_ena = 4'h0; i_state_wea = 4'h0;
  endtask

  task automatic start_run(int n);
    @(negedge clk);
    i_start = 1'b1; i_qbit_num = 6'(n);
    @(negedge clk);
    i_start = 1'b0;
    check("busy_after_start", 256'(o_complete), 256'(0));
  endtask

  task automatic wait_done();
    int cyc;
    cyc = 0;
    while (!o_complete && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
    end
    check("complete", 256'(o_complete), 256'(1));
  endtask

  task automatic read_back(int naddr, int spot, logic [255:0] spot_exp);
    int  total;
    rd_t r;
    total = naddr + ((spot >= 0) ? 1 : 0);
    for (int i = 0; i <= total; i++) begin
      @(negedge clk);
      if (i > 0) begin
        r = sb.pop_front();
        check($sformatf("rd_addr%0d", r.addr), o_state_dout, r.exp);
      end
      if (i < total) begin
        r.addr = (i < naddr) ? i : spot;
        r.exp  = (i < naddr) ? row(i) : spot_exp;
        i_state_ena = 4'hf; i_state_wea = 4'h0; i_state_addra = 16'(r.addr);
        sb.push_back(r);
      end else begin
        i_state_ena = 4'h0;
      end
    end
  endtask

  initial begin
    rd_t   r;
    gate_t gn;
    gn = '{4'd0, 6'd0, 6'd0, 0};
    cases[0] = '{6, 0, 0, gn, gn, gn, 0, {192'd0, ONE}, 0, 0};
    cases[1] = '{6, 0, 1, '{4'd1, 6'd0, 6'd0, 0}, gn, gn, 0, {128'd0, HV, HV}, 1, 0};
    cases[2] = '{6, 0, 1, '{4'd1, 6'd2, 6'd0, 1}, gn, gn, 1, {192'd0, ONE}, 0, 0};
    cases[3] = '{6, 0, 2, '{4'd1, 6'd0, 6'd0, 0}, '{4'd2, 6'd5, 6'd0, 1}, gn, 8, {128'd0, HV, 64'd0}, 0, 0};
    cases[4] = '{5, 1, 3, '{4'd1, 6'd3, 6'd0, 2}, '{4'd2, 6'd1, 6'd4, 2}, '{4'd7, 6'd0, 6'd0, 0}, -1, 256'd0, 0, 0};
    cases[5] = '{6, 1, 3, '{4'd2, 6'd3, 6'd3, 0}, '{4'd1, 6'd6, 6'd0, 0}, '{4'd2, 6'd0, 6'd5, 2}, -1, 256'd0, 0, 0};
    cases[6] = '{4, 1, 2, '{4'd1, 6'd3, 6'd0, 0}, '{4'd2, 6'd2, 6'd0, 2}, gn, -1, 256'd0, 0, 1};

    rst = 1'b1; i_start = 1'b0; i_qbit_num = '0; i_ctx_en = 1'b0; i_ctx_wea = 1'b0;
    i_ctx_addr = '0; i_ctx_data = '0; i_state_ena = '0; i_state_wea = '0;
    i_state_addra = '0; i_state_dina = '0;
    repeat (3) @(negedge clk);
    check("reset_complete", 256'(o_complete), 256'(0));
    check("reset_dout", o_state_dout, 256'd0);
    rst = 1'b0;

    for (int ci = 0; ci < 7; ci++) begin
      load_prog(cases[ci]);
      for (int k = 0; k < 64; k++)
        init_m[k] = cases[ci].rnd ? {$urandom, $urandom} : ((k == 0) ? ONE : 64'd0);
      write_state(cases[ci].n);
      start_run(cases[ci].n);
      if (cases[ci].poke) begin
        // Host write and restart attempt in the middle of the run must be ignored.
        repeat (40) @(negedge clk);
        i_state_ena = 4'hf; i_state_wea = 4'hf; i_state_addra = 16'd0; i_state_dina = '1; i_start = 1'b1;
        @(negedge clk);
        i_state_ena = 4'h0; i_state_wea = 4'h0; i_start = 1'b0;
        check("still_busy", 256'(o_complete), 256'(0));
      end
      if (cases[ci].abort) begin
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_complete", 256'(o_complete), 256'(0));
        check("abort_dout", o_state_dout, 256'd0);
        write_state(cases[ci].n);
        start_run(cases[ci].n);
      end
      wait_done();
      model_gate(cases[ci].g0, cases[ci].n);
      if (cases[ci].ng > 1) model_gate(cases[ci].g1, cases[ci].n);
      if (cases[ci].ng > 2) model_gate(cases[ci].g2, cases[ci].n);
      read_back((1 << cases[ci].n) / 4, cases[ci].spot, cases[ci].spot_exp);
      check($sformatf("complete_hold_case%0d", ci), 256'(o_complete), 256'(1));
    end

    // Read with write enable returns the pre-write word; the next read sees the new one.
    @(negedge clk);
    i_state_ena = 4'hf; i_state_wea = 4'hf; i_state_addra = 16'd2; i_state_dina = {4{64'h01234567_89ABCDEF}};
    r.addr = 2; r.exp = row(2); sb.push_back(r);
    @(negedge clk);
    i_state_wea = 4'h0;
    r = sb.pop_front();
    check("read_first", o_state_dout, r.exp);
    r.addr = 2; r.exp = {4{64'h01234567_89ABCDEF}}; sb.push_back(r);
    @(negedge clk);
    i_state_ena = 4'h0;
    r = sb.pop_front();
    check("after_write", o_state_dout, r.exp);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
